// File: rtl/gam_learning_sequencer.sv
// gam_learning_sequencer: buffers host node patterns and feeds them to the
// GAM Memory_Layer one per READY handshake, then switches it to RECALL.
module gam_learning_sequencer #(
    parameter int NODE_W      = 128,
    parameter int NODE_COUNT  = 5,
    parameter int CLASS_COUNT = 4,
    parameter int DEPTH       = CLASS_COUNT * NODE_COUNT,
    parameter int AW          = $clog2(DEPTH + 1),
    parameter int NW          = $clog2(NODE_COUNT + 1),
    parameter int CW          = $clog2(CLASS_COUNT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_data,
    output logic              wr_full,
    output logic [AW-1:0]     wr_count,
    input  logic [NW-1:0]     cfg_node_count,
    input  logic [CW-1:0]     cfg_class_count,
    input  logic              start,
    input  logic              clear,
    input  logic              ml_ready_wait,
    output logic [NODE_W-1:0] ml_x,
    output logic [31:0]       ml_c,
    output logic              ml_learning_done,
    output logic              ml_learning_recall,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FEED, LAST, RECALL} state_t;

    state_t            state;
    logic [NODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [NW-1:0]     node_ctr, ncfg;
    logic [CW-1:0]     class_ctr, ccfg;
    logic              rdy_s, rdy_q, first;
    logic              wr_ok, cfg_ok, start_ok, rdy_ev, last_pop;

    assign wr_count = wr_ptr - rd_ptr;
    assign wr_full  = (wr_count == AW'(DEPTH));
    assign busy     = (state == FEED) || (state == LAST);
    assign done     = (state == RECALL);

    assign wr_ok  = (state == IDLE) && !wr_full && (wr_data != '0);
    assign cfg_ok = (cfg_node_count != '0)
                 && (cfg_node_count <= NW'(NODE_COUNT))
                 && (cfg_class_count != '0)
                 && (cfg_class_count <= CW'(CLASS_COUNT));
    assign start_ok = (state == IDLE) && cfg_ok
                   && (32'(wr_count) ==
                       32'(cfg_class_count) * 32'(cfg_node_count));

    // ready is sampled once, then edge-detected against its prior sample
    assign rdy_ev   = rdy_s && (!rdy_q || first);
    assign last_pop = (class_ctr == ccfg) && (node_ctr == ncfg);

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok && !clear)
            mem[wr_ptr[IW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            node_ctr           <= NW'(1);
            class_ctr          <= CW'(1);
            ncfg               <= NW'(1);
            ccfg               <= CW'(1);
            rdy_s              <= 1'b0;
            rdy_q              <= 1'b0;
            first              <= 1'b0;
            ml_x               <= '0;
            ml_c               <= '0;
            ml_learning_done   <= 1'b0;
            ml_learning_recall <= 1'b0;
            err                <= 1'b0;
        end else begin
            err   <= 1'b0;
            rdy_s <= ml_ready_wait;
            rdy_q <= rdy_s;
            if (clear) begin
                // ml_x / ml_c deliberately keep their last value
                state              <= IDLE;
                wr_ptr             <= '0;
                rd_ptr             <= '0;
                node_ctr           <= NW'(1);
                class_ctr          <= CW'(1);
                first              <= 1'b0;
                ml_learning_done   <= 1'b0;
                ml_learning_recall <= 1'b0;
            end else begin
                if (wr_en) begin
                    if (wr_ok)
                        wr_ptr <= wr_ptr + AW'(1);
                    else
                        err <= 1'b1;
                end
                if (start && !start_ok)
                    err <= 1'b1;
                unique case (state)
                    IDLE: begin
                        if (start && start_ok) begin
                            state     <= FEED;
                            first     <= 1'b1;
                            ncfg      <= cfg_node_count;
                            ccfg      <= cfg_class_count;
                            node_ctr  <= NW'(1);
                            class_ctr <= CW'(1);
                        end
                    end
                    FEED: begin
                        first <= 1'b0;
                        if (rdy_ev) begin
                            ml_x   <= mem[rd_ptr[IW-1:0]];
                            ml_c   <= 32'(class_ctr);
                            rd_ptr <= rd_ptr + AW'(1);
                            if (node_ctr == ncfg) begin
                                node_ctr  <= NW'(1);
                                class_ctr <= class_ctr + CW'(1);
                            end else begin
                                node_ctr <= node_ctr + NW'(1);
                            end
                            if (last_pop) begin
                                ml_learning_done <= 1'b1;
                                state            <= LAST;
                            end
                        end
                    end
                    LAST: begin
                        if (rdy_ev) begin
                            ml_learning_done   <= 1'b0;
                            ml_learning_recall <= 1'b1;
                            state              <= RECALL;
                        end
                    end
                    RECALL: begin
                        state <= RECALL;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gam_learning_sequencer.sv
// tb_gam_learning_sequencer: scoreboard bench with a queue-based model of
// the pattern buffer and class/node sequencing.
module tb_gam_learning_sequencer;
    localparam int NODE_W      = 128;
    localparam int NODE_COUNT  = 5;
    localparam int CLASS_COUNT = 4;
    localparam int DEPTH       = 20;
    localparam int AW          = 5;
    localparam int NW          = 3;
    localparam int CW          = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [NODE_W-1:0] wr_data;
    logic              wr_full;
    logic [AW-1:0]     wr_count;
    logic [NW-1:0]     cfg_node_count;
    logic [CW-1:0]     cfg_class_count;
    logic              start;
    logic              clear;
    logic              ml_ready_wait;
    logic [NODE_W-1:0] ml_x;
    logic [31:0]       ml_c;
    logic              ml_learning_done;
    logic              ml_learning_recall;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    gam_learning_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .wr_en              (wr_en),
        .wr_data            (wr_data),
        .wr_full            (wr_full),
        .wr_count           (wr_count),
        .cfg_node_count     (cfg_node_count),
        .cfg_class_count    (cfg_class_count),
        .start              (start),
        .clear              (clear),
        .ml_ready_wait      (ml_ready_wait),
        .ml_x               (ml_x),
        .ml_c               (ml_c),
        .ml_learning_done   (ml_learning_done),
        .ml_learning_recall (ml_learning_recall),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    typedef struct {
        logic [NODE_W-1:0] x;
        logic [31:0]       c;
        logic              d;
    } exp_t;

    exp_t              exp_q[$];
    logic [NODE_W-1:0] loaded[$];
    int checks = 0;
    int errors = 0;
    // model phase: 0 idle, 1 feed, 2 last, 3 recall
    int m_state = 0;
    int m_n = 1;
    int m_c = 1;
    int m_k = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NODE_W-1:0] rnd_pat();
        logic [NODE_W-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        if (p == '0) p = 1;
        return p;
    endfunction

    task automatic write(logic [NODE_W-1:0] d);
        logic ok;
        ok = (m_state == 0) && (loaded.size() < DEPTH) && (d != '0);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (ok) loaded.push_back(d);
        chk("wr_err", err, !ok);
        chk("wr_count", wr_count, loaded.size());
        chk("wr_full", wr_full, loaded.size() == DEPTH);
    endtask

    task automatic do_start(int c, int n);
        logic ok;
        ok = (m_state == 0) && (n >= 1) && (n <= NODE_COUNT)
          && (c >= 1) && (c <= CLASS_COUNT) && (loaded.size() == n * c);
        cfg_class_count = c[CW-1:0];
        cfg_node_count  = n[NW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        if (ok) begin
            m_state = 1;
            m_n = n;
            m_c = c;
            m_k = 0;
        end
        chk("start_err", err, !ok);
        chk("start_busy", busy, (m_state == 1) || (m_state == 2));
        chk("start_done", done, m_state == 3);
    endtask

    task automatic ready_pulse(int hold);
        exp_t e;
        logic was_last;
        was_last = 1'b0;
        if (m_state == 1) begin
            e.x = loaded.pop_front();
            e.c = 32'(m_k / m_n + 1);
            e.d = (m_k == m_n * m_c - 1);
            exp_q.push_back(e);
            m_k++;
            if (e.d) m_state = 2;
        end else if (m_state == 2) begin
            m_state  = 3;
            was_last = 1'b1;
        end
        ml_ready_wait = 1'b1;
        repeat (hold) tick();
        ml_ready_wait = 1'b0;
        repeat (2) tick();
        if (was_last) begin
            chk("recall", ml_learning_recall, 1);
            chk("done", done, 1);
            chk("busy_after_last", busy, 0);
            chk("ldone_cleared", ml_learning_done, 0);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        loaded.delete();
        m_state = 0;
        chk("clr_count", wr_count, 0);
        chk("clr_recall", ml_learning_recall, 0);
        chk("clr_done", done, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ldone", ml_learning_done, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_x", ml_x, 0);
        chk("rst_c", ml_c, 0);
        chk("rst_ldone", ml_learning_done, 0);
        chk("rst_recall", ml_learning_recall, 0);
        chk("rst_full", wr_full, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    // monitor: every change of the presented pattern must match the queue
    initial begin
        logic [NODE_W-1:0] px;
        logic [31:0]       pc;
        exp_t              e;
        px = '0;
        pc = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                px = ml_x;
                pc = ml_c;
            end else if (ml_x !== px || ml_c !== pc) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got x=%0h c=%0d expected no change",
                             ml_x, ml_c);
                end else begin
                    e = exp_q.pop_front();
                    chk("ml_x", ml_x, e.x);
                    chk("ml_c", ml_c, e.c);
                    chk("ml_learning_done", ml_learning_done, e.d);
                end
                px = ml_x;
                pc = ml_c;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [NODE_W-1:0] pats [4];
        int c;
        int n;
        reset           = 1'b1;
        wr_en           = 1'b0;
        wr_data         = '0;
        cfg_node_count  = '0;
        cfg_class_count = '0;
        start           = 1'b0;
        clear           = 1'b0;
        ml_ready_wait   = 1'b0;
        #1 reset = 1'b0;
        #1 chk_reset_vals();
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // 1 class x 5 nodes, directed values
        write(1); write(2); write(300); write(4); write(5);
        do_start(1, 5);
        for (int i = 0; i < 5; i++) ready_pulse(1);
        chk("ldone_final", ml_learning_done, 1);
        ready_pulse(1);
        chk("recall_x_hold", ml_x, 5);
        do_start(1, 5);
        chk("recall_still", ml_learning_recall, 1);
        do_clear();

        // 2 classes x 2 nodes
        for (int i = 0; i < 4; i++) begin
            pats[i] = rnd_pat();
            write(pats[i]);
        end
        do_start(2, 2);
        for (int i = 0; i < 5; i++) ready_pulse(2);
        do_clear();

        // rejected writes and start
        write('0);
        for (int i = 0; i < DEPTH + 1; i++) write(rnd_pat());
        do_start(4, 5);
        ready_pulse(1);
        write(rnd_pat());
        do_clear();
        for (int i = 0; i < 3; i++) write(rnd_pat());
        do_start(2, 2);
        chk("idle_count", wr_count, 3);
        do_clear();

        // ready level held for 10 cycles is one event
        for (int i = 0; i < 3; i++) write(rnd_pat());
        do_start(1, 3);
        ready_pulse(10);
        chk("hold_count", wr_count, 2);
        for (int i = 0; i < 3; i++) ready_pulse(1);
        do_clear();

        // asynchronous reset mid-feed
        for (int i = 0; i < 5; i++) write(rnd_pat());
        do_start(1, 5);
        ready_pulse(1);
        ready_pulse(1);
        chk("pending_before_reset", exp_q.size(), 0);
        reset = 1'b0;
        #1 chk_reset_vals();
        loaded.delete();
        m_state = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) write(rnd_pat());
        do_start(1, 5);
        for (int i = 0; i < 6; i++) ready_pulse(1);
        do_clear();

        // randomized configurations
        for (int it = 0; it < 6; it++) begin
            c = $urandom_range(1, CLASS_COUNT);
            n = $urandom_range(1, NODE_COUNT);
            for (int i = 0; i < c * n; i++) write(rnd_pat());
            do_start(c, n);
            for (int i = 0; i < c * n + 1; i++)
                ready_pulse($urandom_range(1, 3));
            if (($urandom & 1) != 0) do_start(c, n);
            do_clear();
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gam_learning_sequencer.md
# gam_learning_sequencer

Controller that sequences training data into the GAM Memory_Layer. It buffers up to CLASS_COUNT×NODE_COUNT node patterns written by a host. On start, it presents them to the memory layer one per READY handshake with the correct class index, and flags the final pattern with learning_done. After the last pattern it switches the memory layer into RECALL mode. It replaces ad-hoc bench-side feeding with a synthesizable block between the host interface and Memory_Layer.

## Interface
- NODE_W, 128, width of node_vector_T.
- NODE_COUNT, 5, maximum nodes per class.
- CLASS_COUNT, 4, maximum classes.
- DEPTH, CLASS_COUNT*NODE_COUNT, pattern buffer entries; AW = $clog2(DEPTH+1).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe.
- wr_data  in  NODE_W  pattern to buffer.
- wr_full  out  1  buffer holds DEPTH entries.
- wr_count  out  AW  entries currently buffered.
- cfg_node_count  in  $clog2(NODE_COUNT+1)  nodes per class, legal 1..NODE_COUNT.
- cfg_class_count  in  $clog2(CLASS_COUNT+1)  classes, legal 1..CLASS_COUNT.
- start  in  1  one-cycle pulse: begin learning.
- clear  in  1  one-cycle pulse: flush and return to IDLE.
- ml_ready_wait  in  1  from Memory_Layer, 1 = READY, 0 = WAIT.
- ml_x  out  NODE_W  pattern to Memory_Layer.
- ml_c  out  32  class index, 1-based.
- ml_learning_done  out  1  high while the final pattern is presented.
- ml_learning_recall  out  1  0 = LEARNING, 1 = RECALL.
- busy  out  1  state is FEED or LAST.
- done  out  1  state is RECALL.
- err  out  1  one-cycle pulse on any rejected write or start.

## Operation
- Buffer: FIFO of DEPTH entries, written class-major (class 1 nodes 1..N, then class 2, ...).
- Writes are accepted only in IDLE when not full and wr_data != 0. Any other write is dropped and pulses err; wr_count is unchanged.
- States are IDLE, FEED, LAST and RECALL.
- IDLE → FEED on start when:
  - wr_count == cfg_class_count*cfg_node_count, and
  - both cfg values are legal.
- Otherwise start pulses err and the block stays in IDLE. cfg values are latched at start.
- Ready event: the cycle ml_ready_wait is 1 and either its registered previous value was 0, or this is the first cycle in FEED.
- FEED, on a ready event:
  - pop the buffer head into ml_x;
  - ml_c ← class_ctr;
  - advance node_ctr 1..cfg_node_count; on wrap, node_ctr ← 1 and class_ctr increments.
- If the popped entry is the last one (class_ctr == cfg_class_count and node_ctr == cfg_node_count), set ml_learning_done = 1 and go to LAST.
- LAST: hold ml_x, ml_c and ml_learning_done. On the next ready event:
  - ml_learning_done ← 0;
  - ml_learning_recall ← 1;
  - go to RECALL.
- RECALL: hold ml_x and ml_c. Ignore ready events and start (start pulses err). Stay until clear.
- clear in any state:
  - flush the buffer; wr_count ← 0;
  - counters ← 1;
  - ml_learning_recall ← 0, ml_learning_done ← 0;
  - go to IDLE. ml_x and ml_c keep their last value.
- A simultaneous clear and start is resolved in favour of clear.
- A simultaneous clear and wr_en flushes the buffer; the write is dropped with no err.

## Timing
- Reset values:
  - ml_x = 0, ml_c = 0;
  - ml_learning_done = 0, ml_learning_recall = 0;
  - wr_full = 0, wr_count = 0;
  - busy = 0, done = 0, err = 0;
  - state IDLE, counters = 1.
- Reset asserted mid-operation forces all of the above immediately, independent of clk.
- Write: entry is visible in wr_count the cycle after wr_en.
- Start latency: start at edge N → busy = 1 from N+1.
- Ready event sampled at edge N → new ml_x, ml_c and ml_learning_done valid after edge N+1 (1-cycle latency).
- ml_x and ml_c never change except on a ready event in FEED, or on reset.
- A ready level held high for many cycles counts as one event. ml_ready_wait must drop to 0 for at least one sampled cycle before the next event.
- LAST→RECALL: ml_learning_recall rises the cycle after the terminating ready event; done rises the same cycle.
- ml_c is never 0 and ml_x is never 0 once presented. Zero patterns are rejected at write time.

## Test plan
- Load patterns 1, 2, 300, 4, 5 with cfg 1 class × 5 nodes, start, then toggle ready 5 times:
  - ml_x = 1, 2, 300, 4, 5 in order, ml_c = 1 throughout;
  - ml_learning_done = 1 only with 5;
  - one more ready event → ml_learning_recall = 1, done = 1.
- Configure 2×2 and load A, B, C, D → ml_c sequence 1, 1, 2, 2; learning_done with D only.
- Write 0, write while full (DEPTH+1 writes), and start with wr_count = 3 against cfg 2×2:
  - each pulses err;
  - wr_count stays 0, then DEPTH, then 3;
  - state stays IDLE.
- Hold ml_ready_wait = 1 for 10 cycles in FEED → exactly one pattern popped.
- Assert reset low mid-FEED after 2 of 5 pops → all outputs at reset values immediately; a subsequent reload and run completes normally.
- In RECALL, pulse start then clear:
  - start pulses err;
  - clear → IDLE, ml_learning_recall = 0, wr_count = 0.
